perf_section_sequencer: RTL

- Avalon-MM master that drives the 4-section performance-counter control slave on behalf of NUM_REQ hardware requesters.
- Converts per-requester go/stop pulses and a global clear request into serialized counter writes, arbitrated round-robin.
- Performs tear-free 64-bit time plus 32-bit event snapshots of one section on request.
- Sits between accelerator logic (message-matching engines) and the counter slave, so hardware can bracket code sections without the CPU.

---
 rtl/perf_section_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/perf_section_sequencer.sv
// perf_section_sequencer
//   Avalon-MM master that turns per-requester go/stop pulses and a global
//   clear into serialized writes to the 4-section performance-counter slave,
//   and takes tear-free {time, events} snapshots of one section on request.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   req_go/req_stop         per-requester start/stop pulses (requester i owns section i)
//   clear                   global counter clear pulse
//   snap_req/snap_sel       snapshot request (level) and section select
//   snap_ack/snap_valid     request accepted / data ready pulses
//   snap_time/snap_events   captured counters, held until the next snap_valid
//   drop_err                sticky: a pulse arrived while its flag was still pending
//   busy                    FSM active or any command pending
//   pc_*                    counter slave bus; pc_readdata is valid one cycle after address
module perf_section_sequencer #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_go,
  input  logic [NUM_REQ-1:0] req_stop,
  input  logic               clear,
  input  logic               snap_req,
  input  logic [1:0]         snap_sel,
  output logic               snap_ack,
  output logic               snap_valid,
  output logic [63:0]        snap_time,
  output logic [31:0]        snap_events,
  output logic [NUM_REQ-1:0] drop_err,
  output logic               busy,
  output logic [3:0]         pc_address,
  output logic               pc_write,
  output logic               pc_begintransfer,
  output logic [31:0]        pc_writedata,
  input  logic [31:0]        pc_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_HI0, S_LO, S_HI1, S_EV, S_CHK, S_DONE
  } state_t;

  // Granted write command, latched in IDLE and issued in WR.
  typedef struct packed {
    logic       clr;
    logic       stop;
    logic [1:0] idx;
    logic [3:0] addr;
  } cmd_t;

  state_t             state, state_nxt;
  cmd_t               cmd;
  logic [NUM_REQ-1:0] go_pend, stop_pend;
  logic               clear_pend;
  logic [1:0]         rr_ptr;
  logic [1:0]         sec;
  logic [31:0]        hi0, lo, hi1;

  logic               gnt_hit, gnt_stop;
  logic [1:0]         gnt_idx;
  logic [NUM_REQ-1:0] svc_go, svc_stop;
  logic               svc_clear;
  logic               hi_match;

  assign hi_match = (hi0 == hi1);
  assign busy     = (state != S_IDLE) | clear_pend | (|go_pend) | (|stop_pend);

  // Round-robin search starting at rr_ptr; stop outranks go within a requester.
  always_comb begin
    int t;
    t        = 0;
    gnt_hit  = 1'b0;
    gnt_idx  = '0;
    gnt_stop = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = int'(rr_ptr) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_hit && (i == t) && (stop_pend[i] | go_pend[i])) begin
          gnt_hit  = 1'b1;
          gnt_idx  = 2'(i);
          gnt_stop = stop_pend[i];
        end
      end
    end
  end

  // Flag being retired by the write issued this cycle.
  always_comb begin
    svc_go    = '0;
    svc_stop  = '0;
    svc_clear = (state == S_WR) && cmd.clr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == S_WR) && !cmd.clr && (cmd.idx == 2'(i))) begin
        if (cmd.stop) svc_stop[i] = 1'b1;
        else          svc_go[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    snap_ack         = 1'b0;
    snap_valid       = 1'b0;
    pc_address       = 4'd3;
    pc_write         = 1'b0;
    pc_begintransfer = 1'b0;
    pc_writedata     = '0;
    case (state)
      S_IDLE: begin
        if (clear_pend || gnt_hit) begin
          state_nxt = S_WR;
        end else if (snap_req) begin
          snap_ack  = 1'b1;
          state_nxt = S_HI0;
        end
      end
      S_WR: begin
        pc_address       = cmd.addr;
        pc_write         = 1'b1;
        pc_begintransfer = 1'b1;
        pc_writedata     = {31'd0, cmd.clr};
        state_nxt        = S_IDLE;
      end
      S_HI0: begin pc_address = {sec, 2'b01}; state_nxt = S_LO;  end
      S_LO:  begin pc_address = {sec, 2'b00}; state_nxt = S_HI1; end
      S_HI1: begin pc_address = {sec, 2'b01}; state_nxt = S_EV;  end
      S_EV:  begin pc_address = {sec, 2'b10}; state_nxt = S_CHK; end
      S_CHK: begin
        if (hi_match) begin
          state_nxt = S_DONE;
        end else begin
          // A carry split the read. This cycle re-issues the hi read so the
          // second pass continues at LO, keeping the retry to four cycles.
          pc_address = {sec, 2'b01};
          state_nxt  = S_LO;
        end
      end
      S_DONE: begin
        snap_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cmd         <= '0;
      go_pend     <= '0;
      stop_pend   <= '0;
      clear_pend  <= 1'b0;
      drop_err    <= '0;
      rr_ptr      <= '0;
      sec         <= '0;
      hi0         <= '0;
      lo          <= '0;
      hi1         <= '0;
      snap_time   <= '0;
      snap_events <= '0;
    end else begin
      state <= state_nxt;
      // A new pulse wins over the retirement of its own flag.
      go_pend    <= (go_pend & ~svc_go) | req_go;
      stop_pend  <= (stop_pend & ~svc_stop) | req_stop;
      clear_pend <= (clear_pend & ~svc_clear) | clear;
      drop_err   <= drop_err | (req_go & go_pend & ~svc_go)
                             | (req_stop & stop_pend & ~svc_stop);
      if (state == S_IDLE) begin
        if (clear_pend) begin
          cmd.clr  <= 1'b1;
          cmd.stop <= 1'b0;
          cmd.idx  <= '0;
          cmd.addr <= 4'd0;
        end else if (gnt_hit) begin
          cmd.clr  <= 1'b0;
          cmd.stop <= gnt_stop;
          cmd.idx  <= gnt_idx;
          cmd.addr <= {gnt_idx, 1'b0, ~gnt_stop};
          if (int'(gnt_idx) == NUM_REQ - 1) rr_ptr <= '0;
          else                              rr_ptr <= gnt_idx + 2'd1;
        end else if (snap_req) begin
          sec <= snap_sel;
        end
      end
      case (state)
        S_LO:  hi0 <= pc_readdata;
        S_HI1: lo  <= pc_readdata;
        S_EV:  hi1 <= pc_readdata;
        S_CHK: begin
          if (hi_match) begin
            snap_time   <= {hi1, lo};
            snap_events <= pc_readdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
